// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 16x16 multiply / divide unit with a register-file
// write-back port. One shift-add (multiply) or restoring shift-subtract
// (divide) step runs per cycle. Every operation takes the same fixed number
// of cycles. After a start is accepted the unit spends 17 cycles in RUN and
// then one cycle in WB.
//
// Optional feature: define MUL_DIV_SIGNED_EN to add the is_signed input.
// With is_signed=1 the operands are treated as two's-complement values.
//
// Parameter:
//   DZ_QUOTIENT  quotient written when a divide has operand_b == 0
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        synchronous, active-low reset
//   start        request a new operation; accepted only in IDLE
//   op           00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder
//   operand_a    multiplicand / dividend
//   operand_b    multiplier / divisor
//   dest_reg     destination register index
//   is_signed    (MUL_DIV_SIGNED_EN only) two's-complement operation
//   busy         high from the accepted start until the return to IDLE
//   done         one-cycle completion pulse, coincident with RegWrite
//   RegWrite     register-file write enable
//   write_reg    latched destination index
//   write_data   selected result
//   div_by_zero  high with done when a divide had a zero divisor
module mul_div_unit #(
    parameter logic [15:0] DZ_QUOTIENT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    input  logic [3:0]  dest_reg,
`ifdef MUL_DIV_SIGNED_EN
    input  logic        is_signed,
`endif
    output logic        busy,
    output logic        done,
    output logic        RegWrite,
    output logic [3:0]  write_reg,
    output logic [15:0] write_data,
    output logic        div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [1:0]  op_q;
    logic [3:0]  dest_q;
    logic [15:0] opnd;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [3:0]  wr_reg_q;
    logic [15:0] wr_data_q;

    logic        signed_mode;
    logic [15:0] mag_a;
    logic [15:0] mag_b;
    logic [16:0] mul_sum;
    logic [16:0] rem_shift;
    logic [15:0] rem_diff;
    logic        rem_ge;
    logic [31:0] product;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic [15:0] result;

`ifdef MUL_DIV_SIGNED_EN
    assign signed_mode = is_signed;
`else
    assign signed_mode = 1'b0;
`endif

    // The core always works on magnitudes. 16'h8000 maps onto itself, and
    // that value is still correct when it is read as unsigned.
    assign mag_a = (signed_mode && operand_a[15]) ? (16'd0 - operand_a) : operand_a;
    assign mag_b = (signed_mode && operand_b[15]) ? (16'd0 - operand_b) : operand_b;

    // Datapath for a single iteration.
    // Multiply: hi:lo holds the partial product, and the multiplier sits in lo.
    // Divide: hi holds the partial remainder, and lo shifts the dividend out
    // while the quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 17'd0);
        rem_shift = {hi, lo[15]};
        rem_ge    = (rem_shift >= {1'b0, opnd});
        rem_diff  = rem_shift[15:0] - opnd;
    end

    // Final sign fix-up and result selection. This is registered into
    // write_data on the last RUN cycle.
    always_comb begin
        product   = {hi, lo};
        quotient  = lo;
        remainder = hi;
        if (neg_q) begin
            product  = 32'd0 - product;
            quotient = 16'd0 - quotient;
        end
        if (neg_r) begin
            remainder = 16'd0 - remainder;
        end
        // A zero divisor leaves |a| in the remainder, and the remainder
        // re-signed by a equals operand_a. Only the quotient is replaced.
        if (dz) begin
            quotient = DZ_QUOTIENT;
        end
        case (op_q)
            2'b00:   result = product[15:0];
            2'b01:   result = product[31:16];
            2'b10:   result = quotient;
            default: result = remainder;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            count     <= 5'd0;
            op_q      <= 2'b00;
            dest_q    <= 4'd0;
            opnd      <= 16'd0;
            hi        <= 16'd0;
            lo        <= 16'd0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            wr_reg_q  <= 4'd0;
            wr_data_q <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        count  <= 5'd0;
                        op_q   <= op;
                        dest_q <= dest_reg;
                        hi     <= 16'd0;
                        opnd   <= op[1] ? mag_b : mag_a;
                        lo     <= op[1] ? mag_a : mag_b;
                        neg_q  <= signed_mode && (operand_a[15] ^ operand_b[15]);
                        neg_r  <= signed_mode && operand_a[15];
                        dz     <= op[1] && (operand_b == 16'd0);
                    end
                end
                S_RUN: begin
                    // Iterations run at counts 0..15. The extra cycle at
                    // count 16 registers the signed result, so write-back
                    // lands in the cycle after the 17th edge.
                    if (count == 5'd16) begin
                        wr_data_q <= result;
                        wr_reg_q  <= dest_q;
                        state     <= S_WB;
                    end else begin
                        count <= count + 5'd1;
                        if (op_q[1]) begin
                            hi <= rem_ge ? rem_diff : rem_shift[15:0];
                            lo <= {lo[14:0], rem_ge};
                        end else begin
                            hi <= mul_sum[16:1];
                            lo <= {mul_sum[0], lo[15:1]};
                        end
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign RegWrite    = (state == S_WB);
    assign done        = (state == S_WB);
    assign div_by_zero = (state == S_WB) && dz;
    assign write_reg   = wr_reg_q;
    assign write_data  = wr_data_q;

endmodule
